mul_operand_feeder: RTL

Upstream sequencer for the 8x8 shift-add multiplier FSM (`fsm_example`). It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It launches one multiplication at a time by driving the multiplier's `input_a`, `input_b` and `init`, waits for `finished`, and presents each 16-bit `result` on a valid/ready output stream in issue order.

---
 rtl/mul_operand_feeder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mul_operand_feeder.sv
// Operand FIFO and launch sequencer for the 8x8 shift-add multiplier.
// Optional WAIT-state abort with sticky err: define FEEDER_TIMEOUT_EN.
module mul_operand_feeder #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_init,
    input  logic               mul_finished,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t          state, next_state;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    logic            timeout_hit;

    assign in_ready  = (count != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign mul_init  = (state == ST_LAUNCH);
    assign out_valid = (state == ST_HOLD);

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state takes its default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (count != '0) next_state = ST_LAUNCH;
            ST_LAUNCH: next_state = ST_WAIT;
            ST_WAIT: begin
                if (mul_finished)     next_state = ST_HOLD;
                else if (timeout_hit) next_state = ST_IDLE;
            end
            ST_HOLD:   if (out_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Operands hold from one pop to the next; the product is captured on WAIT exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            out_result <= '0;
        end else begin
            if (pop) begin
                mul_a <= mem_a[rd_ptr];
                mul_b <= mem_b[rd_ptr];
            end
            if ((state == ST_WAIT) && mul_finished) out_result <= mul_result;
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (state == ST_WAIT) && !mul_finished &&
                         (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == ST_LAUNCH)     wait_cnt <= '0;
            else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
